// File: rtl/fsk_tone_pkg.sv
// Shared constants and bin-bound helper for the multi-tone FSK analyzer.
// Pure elaboration-time content: no latency, no flow control.
package fsk_tone_pkg;

    localparam int MAX_TONES  = 4;
    localparam int EDGE_WIDTH = 16;

    // Half-period window of one tone bin in clocks; all divisions truncate.
    function automatic int bin_bound(input int clock_hz, input int tone_hz,
                                     input int dev_pct, input bit upper);
        int ticks;
        int dev;
        ticks = clock_hz / (2 * tone_hz);
        dev   = (ticks * dev_pct) / 100;
        return upper ? (ticks + dev) : (ticks - dev);
    endfunction

endpackage

// File: rtl/fsk_tone_analyzer_meter.sv
// Synchronizes the tone input and measures clocks between its edges.
// Length strobe 3 clocks after an input change; no backpressure, first edge after reset/enable is a reference only.
module half_period_meter
    import fsk_tone_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     sample_data,
    output logic                     len_vld,
    output logic [COUNTER_WIDTH-1:0] len_dat
);

    logic                     sync1_q, sync1_d;
    logic                     sync2_q, sync2_d;
    logic                     prev_q, prev_d;
    logic                     ref_q, ref_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     len_vld_q, len_vld_d;
    logic [COUNTER_WIDTH-1:0] len_dat_q, len_dat_d;
    logic                     edge_det;
    logic [COUNTER_WIDTH-1:0] len_now;

    always_comb begin
        sync1_d   = sample_data;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        edge_det  = sync2_q ^ prev_q;
        // Saturating length: a stuck input never wraps back into a valid bin.
        len_now   = (cnt_q == '1) ? cnt_q : cnt_q + COUNTER_WIDTH'(1);
        cnt_d     = edge_det ? '0 : len_now;
        ref_d     = ref_q;
        len_vld_d = 1'b0;
        len_dat_d = len_dat_q;
        if (!enable) begin
            ref_d = 1'b0;
        end else if (edge_det) begin
            ref_d = 1'b1;
            if (ref_q) begin
                len_vld_d = 1'b1;
                len_dat_d = len_now;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            ref_q     <= 1'b0;
            cnt_q     <= '0;
            len_vld_q <= 1'b0;
            len_dat_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            len_vld_q <= len_vld_d;
            len_dat_q <= len_dat_d;
        end
    end

    assign len_vld = len_vld_q;
    assign len_dat = len_dat_q;

endmodule

// File: rtl/fsk_tone_analyzer.sv
// Classifies half-periods into tone bins, accumulates per window, latches results and dominant tone.
// Edge-to-classify 4 clocks, result_valid one clock after terminal count; no backpressure, enable=0 freezes the window.
module fsk_tone_analyzer
    import fsk_tone_pkg::*;
#(
    parameter int CLOCK_FREQUENCY   = 50000000,
    parameter int TONE_COUNT        = 2,
    parameter int TONE0_FREQUENCY   = 9000,
    parameter int TONE1_FREQUENCY   = 11000,
    parameter int TONE2_FREQUENCY   = 13000,
    parameter int TONE3_FREQUENCY   = 15000,
    parameter int DEVIATION_PERCENT = 10,
    parameter int WINDOW_TICKS      = 500000,
    parameter int COUNTER_WIDTH     = 32
) (
    input  logic                                 clock,
    input  logic                                 clear,
    input  logic                                 enable,
    input  logic                                 sample_data,
    output logic [MAX_TONES*COUNTER_WIDTH-1:0]   tone_ticks,
    output logic [MAX_TONES*EDGE_WIDTH-1:0]      tone_edges,
    output logic [EDGE_WIDTH-1:0]                reject_count,
    output logic [1:0]                           dominant_tone,
    output logic                                 dominant_valid,
    output logic                                 result_valid
);

    localparam int CW = COUNTER_WIDTH;
    localparam int EW = EDGE_WIDTH;

    localparam logic [CW-1:0] BIN_LO [MAX_TONES] = '{
        CW'(bin_bound(CLOCK_FREQUENCY, TONE0_FREQUENCY, DEVIATION_PERCENT, 1'b0)),
        CW'(bin_bound(CLOCK_FREQUENCY, TONE1_FREQUENCY, DEVIATION_PERCENT, 1'b0)),
        CW'(bin_bound(CLOCK_FREQUENCY, TONE2_FREQUENCY, DEVIATION_PERCENT, 1'b0)),
        CW'(bin_bound(CLOCK_FREQUENCY, TONE3_FREQUENCY, DEVIATION_PERCENT, 1'b0))};
    localparam logic [CW-1:0] BIN_HI [MAX_TONES] = '{
        CW'(bin_bound(CLOCK_FREQUENCY, TONE0_FREQUENCY, DEVIATION_PERCENT, 1'b1)),
        CW'(bin_bound(CLOCK_FREQUENCY, TONE1_FREQUENCY, DEVIATION_PERCENT, 1'b1)),
        CW'(bin_bound(CLOCK_FREQUENCY, TONE2_FREQUENCY, DEVIATION_PERCENT, 1'b1)),
        CW'(bin_bound(CLOCK_FREQUENCY, TONE3_FREQUENCY, DEVIATION_PERCENT, 1'b1))};

    logic          len_vld;
    logic [CW-1:0] len_dat;

    half_period_meter #(.COUNTER_WIDTH(CW)) u_meter (
        .clock       (clock),
        .clear       (clear),
        .enable      (enable),
        .sample_data (sample_data),
        .len_vld     (len_vld),
        .len_dat     (len_dat)
    );

    logic          cls_vld_q, cls_vld_d;
    logic          cls_hit_q, cls_hit_d;
    logic [1:0]    cls_bin_q, cls_bin_d;
    logic [CW-1:0] cls_len_q, cls_len_d;

    logic [CW-1:0] acc_ticks_q [MAX_TONES];
    logic [CW-1:0] acc_ticks_d [MAX_TONES];
    logic [EW-1:0] acc_edges_q [MAX_TONES];
    logic [EW-1:0] acc_edges_d [MAX_TONES];
    logic [EW-1:0] acc_rej_q, acc_rej_d;
    logic [31:0]   win_q, win_d;

    logic [CW-1:0] out_ticks_q [MAX_TONES];
    logic [CW-1:0] out_ticks_d [MAX_TONES];
    logic [EW-1:0] out_edges_q [MAX_TONES];
    logic [EW-1:0] out_edges_d [MAX_TONES];
    logic [EW-1:0] out_rej_q, out_rej_d;
    logic [1:0]    out_dom_q, out_dom_d;
    logic          out_domv_q, out_domv_d;
    logic          rv_q, rv_d;

    logic [CW-1:0] ticks_nx [MAX_TONES];
    logic [EW-1:0] edges_nx [MAX_TONES];
    logic [EW-1:0] rej_nx;
    logic [1:0]    dom_bin;
    logic [EW-1:0] dom_cnt;
    logic          dom_any;
    logic          terminal;

    // Descending scan so the lowest matching bin is the one that sticks.
    always_comb begin
        cls_vld_d = len_vld;
        cls_len_d = len_dat;
        cls_hit_d = 1'b0;
        cls_bin_d = 2'd0;
        for (int i = MAX_TONES - 1; i >= 0; i--) begin
            if (i < TONE_COUNT && len_dat >= BIN_LO[i] && len_dat <= BIN_HI[i]) begin
                cls_hit_d = 1'b1;
                cls_bin_d = 2'(i);
            end
        end
        if (len_dat == '1) cls_hit_d = 1'b0;
    end

    // Accumulators plus the classification retiring this cycle, all saturating.
    always_comb begin
        for (int i = 0; i < MAX_TONES; i++) begin
            ticks_nx[i] = acc_ticks_q[i];
            edges_nx[i] = acc_edges_q[i];
        end
        rej_nx = acc_rej_q;
        if (cls_vld_q) begin
            if (cls_hit_q) begin
                ticks_nx[cls_bin_q] = (cls_len_q > ~acc_ticks_q[cls_bin_q]) ? '1
                                    : acc_ticks_q[cls_bin_q] + cls_len_q;
                edges_nx[cls_bin_q] = (acc_edges_q[cls_bin_q] == '1) ? acc_edges_q[cls_bin_q]
                                    : acc_edges_q[cls_bin_q] + EW'(1);
            end else begin
                rej_nx = (acc_rej_q == '1) ? acc_rej_q : acc_rej_q + EW'(1);
            end
        end
    end

    always_comb begin
        dom_bin = 2'd0;
        dom_cnt = edges_nx[0];
        dom_any = 1'b0;
        for (int i = 0; i < MAX_TONES; i++) begin
            if (edges_nx[i] != '0) dom_any = 1'b1;
        end
        for (int i = 1; i < MAX_TONES; i++) begin
            if (edges_nx[i] > dom_cnt) begin
                dom_cnt = edges_nx[i];
                dom_bin = 2'(i);
            end
        end
    end

    assign terminal = enable && (win_q == 32'(WINDOW_TICKS - 1));

    always_comb begin
        acc_ticks_d = acc_ticks_q;
        acc_edges_d = acc_edges_q;
        acc_rej_d   = acc_rej_q;
        win_d       = win_q;
        out_ticks_d = out_ticks_q;
        out_edges_d = out_edges_q;
        out_rej_d   = out_rej_q;
        out_dom_d   = out_dom_q;
        out_domv_d  = out_domv_q;
        rv_d        = 1'b0;
        if (terminal) begin
            out_ticks_d = ticks_nx;
            out_edges_d = edges_nx;
            out_rej_d   = rej_nx;
            out_dom_d   = dom_bin;
            out_domv_d  = dom_any;
            rv_d        = 1'b1;
            acc_ticks_d = '{default: '0};
            acc_edges_d = '{default: '0};
            acc_rej_d   = '0;
            win_d       = '0;
        end else if (enable) begin
            acc_ticks_d = ticks_nx;
            acc_edges_d = edges_nx;
            acc_rej_d   = rej_nx;
            win_d       = win_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            cls_vld_q   <= 1'b0;
            cls_hit_q   <= 1'b0;
            cls_bin_q   <= 2'd0;
            cls_len_q   <= '0;
            acc_ticks_q <= '{default: '0};
            acc_edges_q <= '{default: '0};
            acc_rej_q   <= '0;
            win_q       <= '0;
            out_ticks_q <= '{default: '0};
            out_edges_q <= '{default: '0};
            out_rej_q   <= '0;
            out_dom_q   <= 2'd0;
            out_domv_q  <= 1'b0;
            rv_q        <= 1'b0;
        end else begin
            cls_vld_q   <= cls_vld_d;
            cls_hit_q   <= cls_hit_d;
            cls_bin_q   <= cls_bin_d;
            cls_len_q   <= cls_len_d;
            acc_ticks_q <= acc_ticks_d;
            acc_edges_q <= acc_edges_d;
            acc_rej_q   <= acc_rej_d;
            win_q       <= win_d;
            out_ticks_q <= out_ticks_d;
            out_edges_q <= out_edges_d;
            out_rej_q   <= out_rej_d;
            out_dom_q   <= out_dom_d;
            out_domv_q  <= out_domv_d;
            rv_q        <= rv_d;
        end
    end

    for (genvar g = 0; g < MAX_TONES; g++) begin : g_out
        assign tone_ticks[g*CW +: CW] = out_ticks_q[g];
        assign tone_edges[g*EW +: EW] = out_edges_q[g];
    end

    assign reject_count   = out_rej_q;
    assign dominant_tone  = out_dom_q;
    assign dominant_valid = out_domv_q;
    assign result_valid   = rv_q;

endmodule
